// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//
// Purpose:
//   Shares one single-ported main-memory interface between the instruction
//   cache and the data cache. Only one requester owns the RAM at a time. The
//   grant is held until the RAM reports ACCESS, and wait/data go back to the
//   owner only. The data cache has static priority.
//
// Optional feature (compile-time macro ARB_FAIRNESS_EN):
//   Adds a 4-bit starvation counter. When the instruction cache has been
//   waiting through STARVE_MAX data-cache completions, the next grant is
//   forced to the instruction cache. Without the macro the counter does not
//   exist, and the instruction cache can starve.
//
// Handshake:
//   A requester raises its request and holds address, data and request until
//   its wait drops to 0. That happens for exactly one cycle, the completion
//   cycle. Dropping the request mid-grant is a withdrawal. The grant is
//   released with no completion pulse.
//
// Ports:
//   CLK, nRST             clock, synchronous active-low reset
//   iREN, iaddr           icache read request and word address
//   iwait, iload          icache stall (0 on completion) and read data
//   dREN, dWEN            dcache read / write requests (write wins)
//   daddr, dstore         dcache word address and write data
//   dwait, dload          dcache stall (0 on completion) and read data
//   ramREN, ramWEN        RAM read / write strobes
//   ramaddr, ramstore     RAM address and write data
//   ramload, ramstate     RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   dbg_state             current arbiter state, for observation only

module cache_mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("cache_mem_arbiter: STARVE_MAX must be in 1..15");
    end

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        SERVE_I  = 2'd1,
        SERVE_D  = 2'd2
    } arb_state_t;

    arb_state_t state;
    arb_state_t next_state;

    logic d_req;
    logic ram_done;
    logic starve;

    assign d_req    = dREN | dWEN;
    // FREE, BUSY and ERROR all mean "keep holding". ERROR is retried by
    // leaving the strobes up.
    assign ram_done = (ramstate == RAM_ACCESS);

`ifdef ARB_FAIRNESS_EN
    logic [3:0] starve_cnt;

    assign starve = iREN && (starve_cnt >= 4'(STARVE_MAX));

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            starve_cnt <= 4'd0;
        end else if (state == ARB_IDLE && !iREN) begin
            starve_cnt <= 4'd0;
        end else if (state == ARB_IDLE && next_state == SERVE_I) begin
            starve_cnt <= 4'd0;
        end else if (state == SERVE_D && d_req && ram_done && iREN
                     && starve_cnt != 4'd15) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign dbg_state = state;

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'd0;
        ramstore   = 32'd0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = 32'd0;
        dload      = 32'd0;

        case (state)
            ARB_IDLE: begin
                if (starve) begin
                    next_state = SERVE_I;
                end else if (d_req) begin
                    next_state = SERVE_D;
                end else if (iREN) begin
                    next_state = SERVE_I;
                end
            end

            SERVE_I: begin
                ramaddr = iaddr;
                iload   = ramload;
                if (!iREN) begin
                    // Withdrawal: release the RAM without a completion pulse.
                    next_state = ARB_IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ram_done) begin
                        iwait      = 1'b0;
                        next_state = ARB_IDLE;
                    end
                end
            end

            SERVE_D: begin
                ramaddr = daddr;
                dload   = ramload;
                if (!d_req) begin
                    next_state = ARB_IDLE;
                end else begin
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ram_done) begin
                        dwait      = 1'b0;
                        next_state = ARB_IDLE;
                    end
                end
            end

            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter.
// Directed cycle-exact scenarios drive ramstate by hand. A randomized phase
// then runs a behavioural RAM with random BUSY/ERROR latency. In that phase,
// driver tasks push expected responses into per-requester queues, and a
// monitor pops and compares them on every completion cycle.

module tb_cache_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 3'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate, dbg_state;

    // RAM side: directed values or the behavioural RAM.
    logic        ram_auto = 1'b0;
    logic [1:0]  dir_state, auto_state;
    logic [31:0] dir_load, auto_load;
    int          busy_left = 0;

    assign ramstate = ram_auto ? auto_state : dir_state;
    assign ramload  = ram_auto ? auto_load  : dir_load;

    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;

    logic [31:0] i_exp_q[$];
    logic [31:0] i_addr_q[$];
    logic [31:0] d_exp_q[$];
    logic [31:0] d_addr_q[$];
    bit          d_wr_q[$];
    logic [31:0] ram_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];

    cache_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ramREN"}, 32'(ramREN), 32'd0);
        check({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
        check({tag, "_ramaddr"}, ramaddr, 32'd0);
        check({tag, "_ramstore"}, ramstore, 32'd0);
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hA5A5_0000 ^ {a[15:0], 16'h0000};
    endfunction

    function automatic logic [31:0] ram_lookup(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_lookup(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // ---------------- behavioural RAM ----------------
    always @(posedge CLK) begin
        #2;
        if (ram_auto && (ramREN || ramWEN)) begin
            if (busy_left > 0) begin
                busy_left--;
                auto_state = ($urandom_range(0, 3) == 0) ? RS_ERROR : RS_BUSY;
                auto_load  = $urandom;
            end else begin
                auto_state = RS_ACCESS;
                auto_load  = ram_lookup(ramaddr);
                busy_left  = $urandom_range(0, 3);
            end
        end else begin
            auto_state = RS_FREE;
            auto_load  = 32'd0;
        end
    end

    always @(negedge CLK) begin
        if (ram_auto && ramWEN && ramstate == RS_ACCESS) ram_mem[ramaddr] = ramstore;
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (mon_en) begin
            if (!iwait) begin
                if (i_exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL i_unexpected: got completion expected none");
                end else begin
                    check("i_load", iload, i_exp_q.pop_front());
                    check("i_addr", ramaddr, i_addr_q.pop_front());
                end
            end
            if (!dwait) begin
                if (d_exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL d_unexpected: got completion expected none");
                end else begin
                    check("d_addr", ramaddr, d_addr_q.pop_front());
                    if (d_wr_q.pop_front()) begin
                        check("d_store", ramstore, d_exp_q.pop_front());
                        check("d_wen", 32'(ramWEN), 32'd1);
                    end else begin
                        check("d_load", dload, d_exp_q.pop_front());
                        check("d_ren", 32'(ramREN), 32'd1);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_i_done();
        int n = 0;
        forever begin
            @(negedge CLK);
            if (!iwait) break;
            n++;
            if (n > 300) begin
                vectors++; miscompares++;
                $display("FAIL i_timeout: got no completion expected one within 300 cycles");
                break;
            end
        end
        next_cycle();
    endtask

    task automatic wait_d_done();
        int n = 0;
        forever begin
            @(negedge CLK);
            if (!dwait) break;
            n++;
            if (n > 300) begin
                vectors++; miscompares++;
                $display("FAIL d_timeout: got no completion expected one within 300 cycles");
                break;
            end
        end
        next_cycle();
    endtask

    task automatic i_driver(input int count);
        logic [31:0] a;
        for (int k = 0; k < count; k++) begin
            a = 32'(4 * $urandom_range(0, 63));
            i_exp_q.push_back(init_val(a));
            i_addr_q.push_back(a);
            iaddr = a;
            iREN  = 1'b1;
            wait_i_done();
            iREN = 1'b0;
            repeat ($urandom_range(0, 3)) next_cycle();
        end
    endtask

    task automatic d_driver(input int count);
        logic [31:0] a, v;
        for (int k = 0; k < count; k++) begin
            a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            d_addr_q.push_back(a);
            daddr = a;
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                ref_mem[a] = v;
                d_exp_q.push_back(v);
                d_wr_q.push_back(1'b1);
                dstore = v;
                dWEN   = 1'b1;
            end else begin
                d_exp_q.push_back(ref_lookup(a));
                d_wr_q.push_back(1'b0);
                dREN = 1'b1;
            end
            wait_d_done();
            dREN = 1'b0;
            dWEN = 1'b0;
            repeat ($urandom_range(1, 3)) next_cycle();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int owners[$];
        int exp_owner;
        int cnt;
        int n;

        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
        dir_state = RS_FREE; dir_load = 32'h0;
        auto_state = RS_FREE; auto_load = 32'h0;

        // Reset with every request high.
        @(posedge CLK); @(posedge CLK); #1;
        @(negedge CLK);
        check_idle("rst");
        check("rst_iwait", 32'(iwait), 32'd1);
        check("rst_dwait", 32'(dwait), 32'd1);
        check("rst_iload", iload, 32'd0);
        check("rst_dload", dload, 32'd0);
        next_cycle(); nRST = 1'b1;
        @(negedge CLK);
        check_idle("post_rst_idle");
        next_cycle(); dir_state = RS_ACCESS;
        @(negedge CLK);
        check("first_grant_wen", 32'(ramWEN), 32'd1);
        check("first_grant_ren", 32'(ramREN), 32'd0);
        check("first_grant_dwait", 32'(dwait), 32'd0);
        check("first_grant_iwait", 32'(iwait), 32'd1);
        next_cycle(); iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; dir_state = RS_FREE;
        next_cycle();

        // Icache read, two BUSY cycles then ACCESS.
        iREN = 1'b1; iaddr = 32'h40; dir_state = RS_BUSY; dir_load = 32'h0BAD0BAD;
        @(negedge CLK);
        check("i_rd_c0_ren", 32'(ramREN), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 3) begin dir_state = RS_ACCESS; dir_load = 32'h8C220004; end
            @(negedge CLK);
            check("i_rd_ren", 32'(ramREN), 32'd1);
            check("i_rd_addr", ramaddr, 32'h40);
            check("i_rd_iwait", 32'(iwait), (c == 3) ? 32'd0 : 32'd1);
        end
        check("i_rd_iload", iload, 32'h8C220004);
        next_cycle(); iREN = 1'b0; dir_state = RS_FREE;
        @(negedge CLK);
        check_idle("i_rd_bubble");
        next_cycle();

        // Simultaneous icache read and dcache write: dcache first.
        iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        dir_state = RS_ACCESS; dir_load = 32'h11112222;
        @(negedge CLK);
        check("sim_c0_iwait", 32'(iwait), 32'd1);
        next_cycle();
        @(negedge CLK);
        check("sim_d_wen", 32'(ramWEN), 32'd1);
        check("sim_d_addr", ramaddr, 32'h100);
        check("sim_d_store", ramstore, 32'hDEADBEEF);
        check("sim_d_dwait", 32'(dwait), 32'd0);
        check("sim_d_iwait", 32'(iwait), 32'd1);
        next_cycle(); dWEN = 1'b0;
        @(negedge CLK);
        check_idle("sim_bubble");
        check("sim_bubble_iwait", 32'(iwait), 32'd1);
        next_cycle();
        @(negedge CLK);
        check("sim_i_ren", 32'(ramREN), 32'd1);
        check("sim_i_addr", ramaddr, 32'h80);
        check("sim_i_iwait", 32'(iwait), 32'd0);
        check("sim_i_iload", iload, 32'h11112222);
        next_cycle(); iREN = 1'b0;
        next_cycle();

        // Two-word write-back, back to back.
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hA0A0_0001;
        next_cycle();
        @(negedge CLK);
        check("wb0_addr", ramaddr, 32'h200);
        check("wb0_store", ramstore, 32'hA0A0_0001);
        check("wb0_dwait", 32'(dwait), 32'd0);
        next_cycle(); daddr = 32'h204; dstore = 32'hB0B0_0002;
        @(negedge CLK);
        check_idle("wb_bubble");
        check("wb_bubble_dwait", 32'(dwait), 32'd1);
        next_cycle();
        @(negedge CLK);
        check("wb1_addr", ramaddr, 32'h204);
        check("wb1_store", ramstore, 32'hB0B0_0002);
        check("wb1_dwait", 32'(dwait), 32'd0);
        next_cycle(); dWEN = 1'b0;
        next_cycle();

        // Withdrawal mid-BUSY.
        dREN = 1'b1; daddr = 32'h300; dir_state = RS_BUSY;
        next_cycle();
        @(negedge CLK);
        check("wd_ren", 32'(ramREN), 32'd1);
        check("wd_dwait", 32'(dwait), 32'd1);
        next_cycle(); dREN = 1'b0;
        @(negedge CLK);
        check("wd_drop_ren", 32'(ramREN), 32'd0);
        check("wd_drop_dwait", 32'(dwait), 32'd1);
        next_cycle();
        @(negedge CLK);
        check_idle("wd_idle");
        check("wd_idle_dwait", 32'(dwait), 32'd1);
        next_cycle();

        // ERROR for one cycle, then ACCESS.
        dREN = 1'b1; daddr = 32'h304; dir_state = RS_ERROR;
        next_cycle();
        @(negedge CLK);
        check("err_ren", 32'(ramREN), 32'd1);
        check("err_dwait", 32'(dwait), 32'd1);
        next_cycle(); dir_state = RS_ACCESS; dir_load = 32'hCAFEF00D;
        @(negedge CLK);
        check("err_retry_ren", 32'(ramREN), 32'd1);
        check("err_retry_addr", ramaddr, 32'h304);
        check("err_retry_dwait", 32'(dwait), 32'd0);
        check("err_retry_dload", dload, 32'hCAFEF00D);
        next_cycle(); dREN = 1'b0; dir_state = RS_FREE;
        next_cycle();

        // Reset during a grant.
        dREN = 1'b1; daddr = 32'h308; dir_state = RS_BUSY;
        next_cycle();
        @(negedge CLK);
        check("rst_mid_ren", 32'(ramREN), 32'd1);
        next_cycle(); nRST = 1'b0;
        next_cycle();
        @(negedge CLK);
        check_idle("rst_mid_after");
        check("rst_mid_dwait", 32'(dwait), 32'd1);
        nRST = 1'b1; dREN = 1'b0; dir_state = RS_FREE;
        next_cycle(); next_cycle();

        // Both caches requesting continuously: record completion owners.
        dREN = 1'b1; daddr = 32'h400; iREN = 1'b1; iaddr = 32'h44; dir_state = RS_ACCESS;
        n = 0;
        while (owners.size() < 5 && n < 30) begin
            @(negedge CLK);
            if (!dwait) owners.push_back(2);
            if (!iwait) owners.push_back(1);
            n++;
            next_cycle();
        end
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
`ifdef ARB_FAIRNESS_EN
            if (cnt >= STARVE_MAX) begin
                exp_owner = 1;
                cnt = 0;
            end else begin
                exp_owner = 2;
                cnt = (cnt < 15) ? cnt + 1 : 15;
            end
`else
            exp_owner = 2;
`endif
            if (k < owners.size()) check("starve_owner", 32'(owners[k]), 32'(exp_owner));
            else check("starve_missing", 32'd0, 32'(exp_owner));
        end
        dREN = 1'b0; iREN = 1'b0; dir_state = RS_FREE;
        next_cycle(); next_cycle();

        // Randomized traffic against the behavioural RAM.
        ram_auto = 1'b1;
        mon_en   = 1'b1;
        next_cycle();
        fork
            i_driver(40);
            d_driver(40);
        join
        next_cycle(); next_cycle();
        mon_en = 1'b0;
        check("i_q_drain", 32'(i_exp_q.size()), 32'd0);
        check("d_q_drain", 32'(d_exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test expected end before 200000");
        $fatal(1);
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single-ported main-memory interface between the instruction cache (read-only, one word per request) and the data cache (word reads and writes, including two-word block fills and write-backs). It sits between the cache controllers and the RAM model. It grants one requester at a time, holds the grant until the RAM completes the access, and returns wait/data to the owner. The data cache has static priority, with optional anti-starvation for the instruction cache.

## Interface
- STARVE_MAX, 4: consecutive data-cache grants tolerated while an instruction request is pending (used only with `ARB_FAIRNESS_EN`); range 1–15.
- CLK  in  1  rising-edge clock
- nRST  in  1  synchronous, active-low reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  icache stall; 0 only on the icache completion cycle
- iload  out  32  read data to icache
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  dcache stall; 0 only on the dcache completion cycle
- dload  out  32  read data to dcache
- ramREN, ramWEN  out  1 each  RAM read/write strobes
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

## Operation
- Registered FSM states: ARB_IDLE, SERVE_I, SERVE_D. All RAM outputs are combinational from the state and the owner's inputs.
- ARB_IDLE:
  - All RAM strobes are 0; ramaddr and ramstore are 0.
  - If dREN|dWEN, go to SERVE_D. Else if iREN, go to SERVE_I. Else stay.
- SERVE_D:
  - ramaddr=daddr.
  - If dWEN: ramWEN=1, ramREN=0, ramstore=dstore. dWEN overrides dREN when both are asserted.
  - Else: ramREN=1, ramstore=0.
  - dload=ramload.
  - ramstate==ACCESS: dwait=0 this cycle; next state ARB_IDLE.
  - dREN and dWEN both 0 (requester withdrew): strobes 0, dwait=1, next state ARB_IDLE.
  - BUSY, FREE or ERROR: dwait=1, stay. ERROR causes a retry by holding the strobes.
- SERVE_I: same rules with ramREN=1, ramaddr=iaddr, iload=ramload, iwait=0 on ACCESS.
- Outside their own completion cycle, iwait and dwait are 1. iload and dload are 0 when not owner.
- The non-owner's request is ignored and held, with its wait at 1, until the FSM returns to ARB_IDLE.

## Timing
- Reset (nRST low at the edge):
  - state = ARB_IDLE.
  - ramREN = ramWEN = 0; ramaddr = ramstore = 0.
  - iwait = dwait = 1; iload = dload = 0.
  - Starvation counter = 0.
- Reset mid-transaction aborts the grant immediately. Strobes drop in the first cycle after the reset edge.
- Latency: a request seen in ARB_IDLE at cycle 0 drives the RAM from cycle 1. With ramstate=ACCESS at cycle 1, wait=0 at cycle 1.
- After completion at cycle k, the FSM is in ARB_IDLE at k+1 (one-cycle bubble) and the next grant starts at k+2.
- Simultaneous dcache and icache requests in ARB_IDLE: dcache wins, unless fairness forces the icache (see Configuration).
- Requesters must hold address, data and request until their wait=0. Behaviour under changes mid-grant is undefined, except for a full withdrawal, which is handled as above.

## Configuration
- `ARB_FAIRNESS_EN` defined:
  - A 4-bit counter increments on each SERVE_D completion while iREN=1.
  - It clears on any SERVE_I entry, or whenever iREN=0 in ARB_IDLE.
  - In ARB_IDLE, if counter ≥ STARVE_MAX and iREN=1, go to SERVE_I even when dcache is requesting.
  - The counter saturates at 15.
- Not defined: the counter is absent and dcache has pure static priority, so the icache can starve indefinitely.

## Test plan
- Reset with all requests high → ramREN=ramWEN=0, iwait=dwait=1. After nRST rises, the first grant goes to SERVE_D.
- iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C220004 → ramREN=1, ramaddr=0x40 for 3 cycles; iwait=0 and iload=0x8C220004 on the third.
- Simultaneous iREN and dWEN (daddr=0x100, dstore=0xDEADBEEF), ACCESS immediate → dcache write completes first. The icache is served starting two cycles later; iwait stays 1 throughout.
- Dcache two-word write-back (0x200, 0x204) back-to-back → two separate SERVE_D grants with a one-cycle ARB_IDLE bubble between them. ramstore matches each word.
- dcache withdraws mid-BUSY, and separately ramstate=ERROR for 1 cycle → withdrawal returns to ARB_IDLE with no completion pulse; the ERROR case holds strobes and completes on the following ACCESS.
- With `ARB_FAIRNESS_EN`, STARVE_MAX=4, dREN and iREN held continuously → after 4 dcache completions the 5th grant is SERVE_I. Without the macro, the icache is never granted.
